// File: rtl/punc_mem_pkg.sv
// Shared types and constants for the PUNC data-memory responder.
package punc_mem_pkg;

    localparam int WORD_W              = 16;
    localparam int WAIT_CYCLES_DEFAULT = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACCESS  = 2'd2,
        ST_RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/punc_mem_array.sv
// Word storage: one synchronous write/registered-read port plus a combinational debug read.
module punc_mem_array
    import punc_mem_pkg::*;
#(
    parameter int MEM_WORDS = 128
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] dbg_addr,
    output logic [WORD_W-1:0] dbg_rdata
);

    localparam int                IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WORD_W:0]   ADDR_LIMIT = MEM_WORDS[WORD_W:0];

    logic [WORD_W-1:0] mem [MEM_WORDS];
    logic              addr_ok;
    logic              dbg_ok;

    // Out-of-range ports never touch the array, even if the caller asks.
    assign addr_ok = {1'b0, addr} < ADDR_LIMIT;
    assign dbg_ok  = {1'b0, dbg_addr} < ADDR_LIMIT;

    always_ff @(posedge clk) begin
        if (wr_en && addr_ok) begin
            mem[addr[IDX_W-1:0]] <= wdata;
        end
        if (rd_en && addr_ok) begin
            rdata <= mem[addr[IDX_W-1:0]];
        end
    end

    assign dbg_rdata = dbg_ok ? mem[dbg_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/punc_dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states in front of each access.
module punc_dmem_responder
    import punc_mem_pkg::*;
#(
    parameter int MEM_WORDS   = 128,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic [15:0] dbg_addr,
    output logic [15:0] dbg_rdata
);

    localparam logic [WORD_W:0] ADDR_LIMIT = MEM_WORDS[WORD_W:0];
    localparam logic [3:0]      WAIT_INIT  = WAIT_CYCLES[3:0];

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        wait_cnt;
    logic              accept;
    logic              lat_wr;
    logic              lat_err;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wdata;
    logic              arr_wr_en;
    logic              arr_rd_en;
    logic [WORD_W-1:0] arr_rdata;

    assign accept = req_valid && (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

    // Request is frozen at accept so the initiator may change its inputs while we work.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_wr    <= 1'b0;
            lat_err   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_wr    <= req_wr;
            lat_err   <= !({1'b0, req_addr} < ADDR_LIMIT);
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ACCESS;
                end
            end
            ST_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: state_nxt = ST_RESPOND;
            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A reset landing on the ACCESS edge must cancel the commit, hence the rst gate.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        arr_wr_en = 1'b0;
        arr_rd_en = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_ACCESS: begin
                arr_wr_en = lat_wr && !lat_err && !rst;
                arr_rd_en = !lat_wr && !lat_err;
            end
            ST_RESPOND: begin
                rsp_valid = 1'b1;
                rsp_err   = lat_err;
                rsp_rdata = (lat_wr || lat_err) ? '0 : arr_rdata;
            end
            default: ;
        endcase
    end

    punc_mem_array #(
        .MEM_WORDS(MEM_WORDS)
    ) u_array (
        .clk      (clk),
        .wr_en    (arr_wr_en),
        .rd_en    (arr_rd_en),
        .addr     (lat_addr),
        .wdata    (lat_wdata),
        .rdata    (arr_rdata),
        .dbg_addr (dbg_addr),
        .dbg_rdata(dbg_rdata)
    );

endmodule

// File: doc/punc_dmem_responder.md
PUNC_DMEM_RESPONDER -- requirements
Module: punc_dmem_responder

Interface
REQ-001 Parameter MEM_WORDS, default 128: number of 16-bit words stored; legal addresses are 0..MEM_WORDS-1.
REQ-002 Parameter WAIT_CYCLES, default 1: number of extra wait-state cycles inserted before each access; legal range 0..15.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 Port req_ready, output, 1 bit: the responder can accept a request this cycle.
REQ-007 Port req_wr, input, 1 bit: 1 = write, 0 = read.
REQ-008 Port req_addr, input, 16 bits: word address.
REQ-009 Port req_wdata, input, 16 bits: write data.
REQ-010 Port rsp_valid, output, 1 bit: response available.
REQ-011 Port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-012 Port rsp_rdata, output, 16 bits: read data; 16'h0000 for writes and errors.
REQ-013 Port rsp_err, output, 1 bit: the request addressed a word at or above MEM_WORDS.
REQ-014 Port dbg_addr, input, 16 bits: debug word address.
REQ-015 Port dbg_rdata, output, 16 bits: combinational read of the array at dbg_addr; 16'h0000 when out of range.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, ACCESS and RESPOND.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-018 On accept, the block SHALL latch req_wr, req_addr and req_wdata and ignore later changes to those inputs.
REQ-019 On accept, the next state SHALL be WAIT with the wait counter loaded to WAIT_CYCLES when WAIT_CYCLES>0, otherwise ACCESS.
REQ-020 In WAIT the counter SHALL decrement each cycle; on the cycle it reads 1, the next state SHALL be ACCESS.
REQ-021 ACCESS SHALL last exactly one cycle; a write commits to the array at the end of ACCESS, and read data is registered at the same edge.
REQ-022 ACCESS SHALL always be followed by RESPOND, in which rsp_valid=1; first rsp_valid is WAIT_CYCLES+2 cycles after the accept edge.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL stay stable in RESPOND until the edge where rsp_ready=1, after which the next state is IDLE.
REQ-024 Only one request SHALL be outstanding at a time; a new accept is possible no earlier than the cycle after the response handshake.
REQ-025 An out-of-range request SHALL follow the same timing and return rsp_err=1 and rsp_rdata=16'h0000; an out-of-range write SHALL not modify the array.
REQ-026 For an in-range write, the response SHALL carry rsp_err=0 and rsp_rdata=16'h0000.
REQ-027 A read of an address written by the immediately preceding write SHALL return the new data.
REQ-028 dbg_rdata SHALL reflect a write combinationally from the cycle after the commit edge.
REQ-029 rsp_valid SHALL be 0 in every state except RESPOND.

Reset
REQ-030 When rst=1 at an edge: state becomes IDLE, rsp_valid=0, rsp_rdata=16'h0000, rsp_err=0, wait counter=0, and the latched request is cleared.
REQ-031 A reset in WAIT or ACCESS SHALL discard the pending request; a write not yet committed SHALL never reach the array.
REQ-032 Reset SHALL not clear array contents.
REQ-033 req_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-034 The shared package punc_mem_pkg SHALL hold the state enumeration, the 16-bit word width constant and the WAIT_CYCLES default.
REQ-035 The storage SHALL be a sub-module punc_mem_array with one synchronous write/read port and one combinational debug read port; the FSM and counter SHALL live in the top.

Verification
REQ-036 Write then read, WAIT_CYCLES=1: write addr 16'h0005, data 16'hBEEF, then read 16'h0005 -> rsp_valid 3 cycles after each accept, read returns 16'hBEEF, rsp_err=0.
REQ-037 Out of range: write 16'h0080, data 16'h1234, then read 16'h0080 -> both responses have rsp_err=1, rsp_rdata=16'h0000, and dbg_rdata of every address is unchanged.
REQ-038 Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stay stable and req_ready stays 0; one cycle after rsp_ready=1, req_ready=1.
REQ-039 Reset mid-write: WAIT_CYCLES=3, write 16'h0010, data 16'hAAAA, assert rst in the second WAIT cycle -> dbg_rdata at 16'h0010 keeps its old value, rsp_valid never rises, req_ready=1 after reset.
REQ-040 Zero wait: WAIT_CYCLES=0, read 16'h0000 -> rsp_valid exactly 2 cycles after accept.
REQ-041 Input hold-off: change req_addr and req_wdata while in WAIT -> the access uses the values latched at accept.
